pwm_decoder: RTL and testbench

PWM_DECODER -- requirements
Module: pwm_decoder

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_edge_sync.sv | 30 +++
 rtl/pwm_decoder.sv | 140 ++++++++++++++
 tb/tb_pwm_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and state type for the PWM duty decoder
package pwm_pkg;

    localparam int PERIOD_DEF = 16;
    localparam int DUTY_W_DEF = 4;
    localparam int CNT_W_DEF  = $clog2(PERIOD_DEF) + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - two-flop synchronizer with rising-edge detect
module pwm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic meta;
    logic sync;
    logic hist;

    // Bring the asynchronous input into the clk domain and keep one cycle of history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            hist <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~hist;

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - recovers the high-cycle count of each PWM frame
module pwm_decoder
    import pwm_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF,
    parameter int DUTY_W = DUTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_valid,
    output logic              period_err
);

    localparam int CNT_W = $clog2(PERIOD) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W:0]   FRAME_LEN = (CNT_W + 1)'(PERIOD);

    logic pwm_s;
    logic rise;

    pwm_state_t        state, state_nx;
    logic [CNT_W-1:0]  hi_cnt, hi_nx;
    logic [CNT_W-1:0]  lo_cnt, lo_nx;
    logic [DUTY_W-1:0] duty_nx;
    logic              valid_nx;
    logic              err_nx;

    logic [CNT_W-1:0]  hi_inc;
    logic [CNT_W-1:0]  lo_inc;
    logic [CNT_W:0]    frame_sum;

    pwm_edge_sync u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (pwm_in),
        .q    (pwm_s),
        .rise (rise)
    );

    // Saturating increments and the single frame-length adder
    always_comb begin
        hi_inc    = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + 1'b1;
        lo_inc    = (lo_cnt == CNT_MAX) ? lo_cnt : lo_cnt + 1'b1;
        frame_sum = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    end

    // Next state, counters and result pulses; in IDLE lo_cnt tracks the low run
    always_comb begin
        state_nx = state;
        hi_nx    = hi_cnt;
        lo_nx    = lo_cnt;
        duty_nx  = duty_out;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_nx = ST_HIGH;
                    hi_nx    = CNT_W'(1);
                    lo_nx    = '0;
                end else if (pwm_s) begin
                    lo_nx = '0;
                end else if (lo_cnt == PERIOD_M1) begin
                    duty_nx  = '0;
                    valid_nx = 1'b1;
                    lo_nx    = '0;
                end else begin
                    lo_nx = lo_inc;
                end
            end
            ST_HIGH: begin
                if (pwm_s) begin
                    if (hi_cnt == PERIOD_M1) begin
                        // A full frame of high can only be a stuck input
                        err_nx   = 1'b1;
                        state_nx = ST_IDLE;
                        hi_nx    = '0;
                        lo_nx    = '0;
                    end else begin
                        hi_nx = hi_inc;
                    end
                end else begin
                    state_nx = ST_LOW;
                    lo_nx    = CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (rise) begin
                    if (frame_sum == FRAME_LEN) begin
                        duty_nx  = DUTY_W'(hi_cnt);
                        valid_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                    state_nx = ST_HIGH;
                    hi_nx    = CNT_W'(1);
                    lo_nx    = '0;
                end else if (!pwm_s) begin
                    if (lo_cnt == PERIOD_M1) begin
                        duty_nx  = '0;
                        valid_nx = 1'b1;
                        state_nx = ST_IDLE;
                        hi_nx    = '0;
                        lo_nx    = '0;
                    end else begin
                        lo_nx = lo_inc;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                hi_nx    = '0;
                lo_nx    = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hi_cnt     <= '0;
            lo_cnt     <= '0;
            duty_out   <= '0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
        end else begin
            state      <= state_nx;
            hi_cnt     <= hi_nx;
            lo_cnt     <= lo_nx;
            duty_out   <= duty_nx;
            duty_valid <= valid_nx;
            period_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - directed table-driven bench for pwm_decoder
module tb_pwm_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_in = 1'b0;
    logic [3:0] duty_out;
    logic       duty_valid;
    logic       period_err;

    pwm_decoder #(.PERIOD(16), .DUTY_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .duty_out  (duty_out),
        .duty_valid(duty_valid),
        .period_err(period_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int nfr;
        int exp_valid;
        int exp_err;
        int exp_duty;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rel_cyc = 0;
    int   n_valid = 0;
    int   n_err = 0;
    int   valid_cycs[$];
    int   err_cycs[$];
    logic [3:0] err_duty = '0;
    bit   both_seen = 0;
    bit   wide_seen = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;

    // Pulse monitor sampled away from the active edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (duty_valid === 1'b1) begin
            n_valid = n_valid + 1;
            valid_cycs.push_back(cyc);
        end
        if (period_err === 1'b1) begin
            n_err = n_err + 1;
            err_cycs.push_back(cyc);
            err_duty = duty_out;
        end
        if (duty_valid === 1'b1 && period_err === 1'b1) both_seen = 1;
        if ((duty_valid === 1'b1 && prev_v === 1'b1) || (period_err === 1'b1 && prev_e === 1'b1))
            wide_seen = 1;
        prev_v = duty_valid;
        prev_e = period_err;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int vc_at(input int i);
        if (i < valid_cycs.size()) return valid_cycs[i] - rel_cyc;
        return -1;
    endfunction

    function automatic int ec_at(input int i);
        if (i < err_cycs.size()) return err_cycs[i] - rel_cyc;
        return -1;
    endfunction

    task automatic tick(input logic v);
        pwm_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rel_cyc = cyc + 1;
    endtask

    task automatic frame(input int hi, input int lo);
        repeat (hi) tick(1'b1);
        repeat (lo) tick(1'b0);
    endtask

    task automatic close_frame();
        repeat (6) tick(1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t vecs[$];
        int   bv, be, bq, bqe;

        for (int d = 1; d <= 15; d++) vecs.push_back('{d, 16 - d, 2, 2, 0, d});
        vecs.push_back('{5, 8, 1, 0, 1, 0});
        vecs.push_back('{10, 10, 1, 0, 1, 0});
        vecs.push_back('{5, 11, 3, 3, 0, 5});

        // Reset state
        @(posedge clk);
        #1;
        chk("reset_duty", duty_out, 0);
        chk("reset_valid", duty_valid, 0);
        chk("reset_err", period_err, 0);

        // Table of uniform frame streams, each closed by a trailing rise
        foreach (vecs[i]) begin
            do_reset();
            bv = n_valid;
            be = n_err;
            repeat (vecs[i].nfr) frame(vecs[i].hi, vecs[i].lo);
            close_frame();
            chk($sformatf("vec%0d_valid_cnt", i), n_valid - bv, vecs[i].exp_valid);
            chk($sformatf("vec%0d_err_cnt", i), n_err - be, vecs[i].exp_err);
            chk($sformatf("vec%0d_duty", i), duty_out, vecs[i].exp_duty);
        end

        // Three 5/11 frames: results at the rises that start frames 2 and 3
        do_reset();
        bv = n_valid;
        be = n_err;
        bq = valid_cycs.size();
        repeat (3) frame(5, 11);
        repeat (3) tick(1'b0);
        chk("d5_valid_cnt", n_valid - bv, 2);
        chk("d5_err_cnt", n_err - be, 0);
        chk("d5_first_valid_cycle", vc_at(bq), 19);
        chk("d5_second_valid_cycle", vc_at(bq + 1), 35);
        chk("d5_duty", duty_out, 5);

        // Input held low: zero-duty result every 16 cycles
        do_reset();
        bv = n_valid;
        be = n_err;
        bq = valid_cycs.size();
        repeat (40) tick(1'b0);
        chk("low_valid_cnt", n_valid - bv, 2);
        chk("low_first_cycle", vc_at(bq), 16);
        chk("low_second_cycle", vc_at(bq + 1), 32);
        chk("low_err_cnt", n_err - be, 0);
        chk("low_duty", duty_out, 0);

        // Short frame: error keeps the previous duty, next good frame recovers
        do_reset();
        bv = n_valid;
        be = n_err;
        frame(3, 13);
        frame(5, 8);
        frame(6, 10);
        close_frame();
        chk("short_valid_cnt", n_valid - bv, 2);
        chk("short_err_cnt", n_err - be, 1);
        chk("short_duty_at_err", err_duty, 3);
        chk("short_duty_after", duty_out, 6);

        // Stuck high: one error at the 16th high sample, resync on the next rise
        do_reset();
        bv  = n_valid;
        be  = n_err;
        bqe = err_cycs.size();
        frame(5, 11);
        repeat (20) tick(1'b1);
        chk("stuck_err_cnt_mid", n_err - be, 1);
        chk("stuck_err_cycle", ec_at(bqe), 34);
        chk("stuck_duty_at_err", err_duty, 5);
        repeat (4) tick(1'b0);
        frame(7, 9);
        close_frame();
        chk("stuck_valid_cnt", n_valid - bv, 2);
        chk("stuck_err_cnt", n_err - be, 1);
        chk("stuck_duty_after", duty_out, 7);

        // Reset in the middle of a high phase of a duty-7 stream
        do_reset();
        bv = n_valid;
        be = n_err;
        repeat (2) frame(7, 9);
        repeat (4) tick(1'b1);
        chk("cut_pre_valid_cnt", n_valid - bv, 2);
        chk("cut_pre_duty", duty_out, 7);
        pwm_in = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        chk("cut_rst_duty", duty_out, 0);
        chk("cut_rst_valid", duty_valid, 0);
        chk("cut_rst_err", period_err, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        rel_cyc = cyc + 1;
        bv = n_valid;
        be = n_err;
        frame(7, 9);
        chk("cut_first_frame_valid_cnt", n_valid - bv, 0);
        frame(7, 9);
        close_frame();
        chk("cut_valid_cnt", n_valid - bv, 2);
        chk("cut_err_cnt", n_err - be, 0);
        chk("cut_duty", duty_out, 7);

        chk("pulse_overlap", both_seen, 0);
        chk("pulse_width", wide_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
